acc_tdm_sched: RTL

- Round-based TDM scheduler that feeds the per-channel accumulator datapath.
- Takes NUM_CHANNELS independent valid/ready sample streams and assembles each round into a burst of NUM_CHANNELS back-to-back beats.
- Each round is issued in channel order 0..NUM_CHANNELS-1, which is what the accumulator's channel-0-restart scheme requires.
- Marks the last beat of every FRAME_LEN-th round with tlast, and handles stalled or missing inputs with a timeout and a sticky underrun flag.

---
 rtl/acc_sched_pkg.sv | 21 ++
 rtl/acc_tdm_sched_if.sv | 30 +++
 rtl/acc_frame_cnt.sv | 40 ++++
 rtl/acc_tdm_sched.sv | 137 +++++++++++++
 4 files changed

// File: rtl/acc_sched_pkg.sv
// Shared types and defaults for the accumulator TDM scheduler.
package acc_sched_pkg;

  localparam int unsigned DEF_NUM_CHANNELS = 4;
  localparam int unsigned DEF_DATA_W       = 14;
  localparam int unsigned DEF_FRAME_LEN    = 16;
  localparam int unsigned DEF_TIMEOUT      = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ISSUE   = 2'd2,
    DRAIN   = 2'd3
  } sched_state_e;

  // Channel index width for a given channel count (never below one bit).
  function automatic int unsigned chn_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_tdm_sched_if.sv
// Sample-stream bundle: per-channel valid/ready inputs and the beat stream to the accumulator.
interface acc_tdm_sched_if
  import acc_sched_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int unsigned DATA_W       = DEF_DATA_W
);

  localparam int unsigned CHN_W = chn_width(NUM_CHANNELS);

  logic [NUM_CHANNELS*DATA_W-1:0] s_dat;
  logic [NUM_CHANNELS-1:0]        s_vld;
  logic [NUM_CHANNELS-1:0]        s_rdy;
  logic [DATA_W-1:0]              o_stm_dat;
  logic [CHN_W-1:0]               o_stm_chn;
  logic                           o_vld;
  logic                           o_tlast;

  // master is the scheduler; slave is the environment (sources plus accumulator).
  modport master (
    input  s_dat, s_vld,
    output s_rdy, o_stm_dat, o_stm_chn, o_vld, o_tlast
  );

  modport slave (
    output s_dat, s_vld,
    input  s_rdy, o_stm_dat, o_stm_chn, o_vld, o_tlast
  );

endinterface

// File: rtl/acc_frame_cnt.sv
// Wrapping round counter that flags the last round of a frame; a clear seen mid-round
// is held until the round boundary so the running round's tlast decision is kept.
module acc_frame_cnt
  import acc_sched_pkg::*;
#(
  parameter int unsigned FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_in_round,
  input  logic i_round_end,
  output logic o_last_c
);

  localparam int unsigned CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             clr_pend_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q      <= '0;
      clr_pend_q <= 1'b0;
    end else if (i_round_end) begin
      cnt_q      <= (i_clr || clr_pend_q || (cnt_q == CNT_LAST)) ? '0 : cnt_q + 1'b1;
      clr_pend_q <= 1'b0;
    end else if (i_clr) begin
      if (i_in_round) begin
        clr_pend_q <= 1'b1;
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign o_last_c = (cnt_q == CNT_LAST);

endmodule

// File: rtl/acc_tdm_sched.sv
// Round-based TDM scheduler: collects one sample per channel, then issues them as a
// contiguous channel-ordered burst with frame tlast, timeout-forced rounds and underrun flag.
module acc_tdm_sched
  import acc_sched_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned FRAME_LEN    = DEF_FRAME_LEN,
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_clr,
  acc_tdm_sched_if.master        bus,
  output logic                   o_underrun,
  output logic                   o_busy
);

  localparam int unsigned CHN_W = chn_width(NUM_CHANNELS);
  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CHN_W-1:0] LAST_BEAT = CHN_W'(NUM_CHANNELS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

  sched_state_e     state_q, state_d;
  logic [CHN_W-1:0] beat_q, beat_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [DATA_W-1:0] ch_dat [NUM_CHANNELS];
  logic             beat_vld;
  logic             in_issue;
  logic             round_end;
  logic             last_round;

  // Unpack the flat sample bus into per-channel lanes.
  always_comb begin
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      ch_dat[k] = bus.s_dat[k*DATA_W +: DATA_W];
    end
  end

  assign in_issue = (state_q == ISSUE);
  assign beat_vld = bus.s_vld[beat_q];

  // State, beat index and timeout counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic; the timeout only advances once some channel has data.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    tmo_d     = '0;
    round_end = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_en) state_d = COLLECT;
      end
      COLLECT: begin
        tmo_d = tmo_q;
        if (&bus.s_vld) begin
          state_d = ISSUE;
        end else if (|bus.s_vld) begin
          if (tmo_q == TMO_LAST) begin
            state_d = ISSUE;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      ISSUE: begin
        if (beat_q == LAST_BEAT) begin
          round_end = 1'b1;
          beat_d    = '0;
          state_d   = i_en ? COLLECT : DRAIN;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pop only the channel in the current beat slot, and only if it actually holds data.
  always_comb begin
    bus.s_rdy = '0;
    if (in_issue) bus.s_rdy[beat_q] = beat_vld;
  end

  acc_frame_cnt #(
    .FRAME_LEN (FRAME_LEN)
  ) u_frame_cnt (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clr       (i_clr),
    .i_in_round  (in_issue),
    .i_round_end (round_end),
    .o_last_c    (last_round)
  );

  // One output register stage behind the beat select; a missing channel issues a zero beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_vld     <= 1'b0;
      bus.o_stm_chn <= '0;
      bus.o_stm_dat <= '0;
      bus.o_tlast   <= 1'b0;
      o_underrun    <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      bus.o_vld     <= in_issue;
      bus.o_stm_chn <= in_issue ? beat_q : '0;
      bus.o_stm_dat <= (in_issue && beat_vld) ? ch_dat[beat_q] : '0;
      bus.o_tlast   <= round_end && last_round;
      o_busy        <= (state_d != IDLE);
      if (in_issue && !beat_vld) begin
        o_underrun <= 1'b1;
      end else if (i_clr) begin
        o_underrun <= 1'b0;
      end
    end
  end

endmodule
